// File: rtl/pp_interpolator_2.sv
// pp_interpolator_2 -- polyphase interpolate-by-2 FIR.
//
// Every accepted input sample x[n] produces two output samples in order:
//   y0 = sum_k h0[k]*x[n-k]   (registered on the accept edge)
//   y1 = sum_k h1[k]*x[n-k]   (held in ph1_q, emitted on the following edge)
// Both phases read the same input delay line. Arithmetic is full precision.
//
// Handshake: an input transfer happens on a rising clk edge when
// valid_in & ready_in are both high. ready_in is low only while y1 is still
// pending (state PH0). The output has no backpressure. valid_out marks the
// single cycle in which data_out carries a new sample.
//
// Optional feature macro: PP_INTERP_BYPASS_EN adds a bypass input. It passes
// data_in straight through, scaled by 2^(COEFF_WIDTH-1), and parks the filter.
//
// Ports:
//   clk        in   clock
//   arst_n     in   synchronous active-low reset
//   data_in    in   signed input sample [DATA_WIDTH]
//   valid_in   in   data_in valid
//   ready_in   out  block can accept a sample this cycle
//   data_out   out  signed interpolated sample [OUT_WIDTH]
//   valid_out  out  data_out valid this cycle
//   bypass     in   (PP_INTERP_BYPASS_EN only) pass-through select
module pp_interpolator_2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 5,
  parameter int N_COEFFS_0  = 2,
  parameter int N_COEFFS_1  = 1,
  parameter logic [N_COEFFS_0*COEFF_WIDTH-1:0] COEFFS_0 = 10'h061,
  parameter logic [N_COEFFS_1*COEFF_WIDTH-1:0] COEFFS_1 = 5'd4,
  localparam int NMAX      = (N_COEFFS_0 > N_COEFFS_1) ? N_COEFFS_0 : N_COEFFS_1,
  localparam int OUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(NMAX) + 1
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        valid_out
`ifdef PP_INTERP_BYPASS_EN
  ,
  input  logic                        bypass
`endif
);

  // Delay line keeps NMAX-1 past samples; sized to at least one entry so
  // the declaration stays legal when both phases have a single tap.
  localparam int DL_SZ = (NMAX > 1) ? NMAX - 1 : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PH0 = 2'd1, PH1 = 2'd2} state_t;

  state_t                       state, state_d;
  logic signed [DATA_WIDTH-1:0] dl [DL_SZ];
  logic signed [DATA_WIDTH-1:0] taps [NMAX];
  logic signed [OUT_WIDTH-1:0]  y0, y1;
  logic signed [OUT_WIDTH-1:0]  data_q, data_d;
  logic signed [OUT_WIDTH-1:0]  ph1_q, ph1_d;
  logic                         valid_q, valid_d;
  logic                         shift;
  logic                         fsm_ready;

  function automatic logic signed [OUT_WIDTH-1:0] sx_c(input logic [COEFF_WIDTH-1:0] c);
    return {{(OUT_WIDTH-COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sx_d(input logic [DATA_WIDTH-1:0] d);
    return {{(OUT_WIDTH-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
  endfunction

  // Tap 0 is the incoming sample, tap k is the k-th oldest stored sample.
  always_comb begin
    taps[0] = data_in;
    for (int k = 1; k < NMAX; k++) taps[k] = dl[k-1];
  end

  // Operands are widened to OUT_WIDTH first, so the truncated product is exact.
  always_comb begin
    y0 = '0;
    for (int k = 0; k < N_COEFFS_0; k++)
      y0 = y0 + sx_c(COEFFS_0[k*COEFF_WIDTH +: COEFF_WIDTH]) * sx_d(taps[k]);
  end

  always_comb begin
    y1 = '0;
    for (int k = 0; k < N_COEFFS_1; k++)
      y1 = y1 + sx_c(COEFFS_1[k*COEFF_WIDTH +: COEFF_WIDTH]) * sx_d(taps[k]);
  end

  assign fsm_ready = (state != PH0);

  // Next-state and datapath control.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    ph1_d   = ph1_q;
    valid_d = 1'b0;
    shift   = 1'b0;
    case (state)
      PH0: begin
        data_d  = ph1_q;
        valid_d = 1'b1;
        state_d = PH1;
      end
      default: begin // IDLE, PH1
        if (valid_in) begin
          data_d  = y0;
          ph1_d   = y1;
          valid_d = 1'b1;
          shift   = 1'b1;
          state_d = PH0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
`ifdef PP_INTERP_BYPASS_EN
    // Bypass parks the filter: pending y1 dropped, delay line frozen.
    if (bypass) begin
      state_d = IDLE;
      data_d  = data_q;
      ph1_d   = ph1_q;
      valid_d = 1'b0;
      shift   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      ph1_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DL_SZ; i++) dl[i] <= '0;
    end else begin
      state   <= state_d;
      data_q  <= data_d;
      ph1_q   <= ph1_d;
      valid_q <= valid_d;
      if (shift && NMAX > 1) begin
        for (int i = DL_SZ - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= data_in;
      end
    end
  end

`ifdef PP_INTERP_BYPASS_EN
  logic signed [OUT_WIDTH-1:0] byp_val;
  assign byp_val   = {{(OUT_WIDTH-DATA_WIDTH-COEFF_WIDTH+1){data_in[DATA_WIDTH-1]}},
                      data_in, {(COEFF_WIDTH-1){1'b0}}};
  assign ready_in  = bypass ? 1'b1     : fsm_ready;
  assign data_out  = bypass ? byp_val  : data_q;
  assign valid_out = bypass ? valid_in : valid_q;
`else
  assign ready_in  = fsm_ready;
  assign data_out  = data_q;
  assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_pp_interpolator_2.sv
// Testbench for pp_interpolator_2 at default parameters (h0={1,3}, h1={4}).
// Inputs are driven just after the falling edge; ready_in is sampled 1 ns
// later and the registered outputs are sampled at the next falling edge.
module tb_pp_interpolator_2;

  localparam int DW = 16;
  localparam int OW = 23;

  logic                 clk;
  logic                 arst_n;
  logic signed [DW-1:0] data_in;
  logic                 valid_in;
  logic                 ready_in;
  logic signed [OW-1:0] data_out;
  logic                 valid_out;
`ifdef PP_INTERP_BYPASS_EN
  logic                 bypass;
`endif

  pp_interpolator_2 dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out)
`ifdef PP_INTERP_BYPASS_EN
    ,
    .bypass   (bypass)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Outputs still owed to the downstream, in order; the block is busy
  // whenever this queue is non-empty.
  logic [OW-1:0] exp_q[$];
  int            hist[$];          // past accepted samples, newest first
  int            h0[2] = '{1, 3};
  int            h1[1] = '{4};
  bit            mdl_ready, mdl_valid;
  int            mdl_data;

  bit            act_ready, act_valid;
  int            act_data;

  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist = '{0};
    mdl_valid = 1'b0;
    mdl_data  = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit rst_n, input bit v, input int d);
    int y0, y1, smp;
    arst_n   = rst_n;
    valid_in = v;
    data_in  = d[DW-1:0];
    smp      = int'(data_in);
    #1;
    act_ready = ready_in;
    mdl_ready = (exp_q.size() == 0);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (exp_q.size() != 0) begin
      mdl_data  = int'($signed(exp_q.pop_front()));
      mdl_valid = 1'b1;
    end else if (v) begin
      y0 = h0[0] * smp + h0[1] * hist[0];
      y1 = h1[0] * smp;
      exp_q.push_back(OW'(y1));
      mdl_data  = y0;
      mdl_valid = 1'b1;
      hist.push_front(smp);
      void'(hist.pop_back());
    end else begin
      mdl_valid = 1'b0;
    end
    @(negedge clk);
    act_valid = valid_out;
    act_data  = int'(data_out);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ready"}, int'(act_ready), int'(mdl_ready));
    check({tag, "_valid"}, int'(act_valid), int'(mdl_valid));
    check({tag, "_data"},  act_data,        mdl_data);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit v;
    int d;
    bit e_rdy;
    bit e_val;
    int e_dat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int accepted;
    int k;

    // impulse
    tbl[0]  = '{1'b1, 100,    1'b1, 1'b1, 100};
    tbl[1]  = '{1'b0, 0,      1'b0, 1'b1, 400};
    tbl[2]  = '{1'b1, 0,      1'b1, 1'b1, 300};
    tbl[3]  = '{1'b0, 0,      1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 0,      1'b1, 1'b1, 0};
    tbl[5]  = '{1'b0, 0,      1'b0, 1'b1, 0};
    tbl[6]  = '{1'b0, 0,      1'b1, 1'b0, 0};
    // extremes
    tbl[7]  = '{1'b1, -32768, 1'b1, 1'b1, -32768};
    tbl[8]  = '{1'b0, 0,      1'b0, 1'b1, -131072};
    tbl[9]  = '{1'b1, -32768, 1'b1, 1'b1, -131072};
    tbl[10] = '{1'b0, 0,      1'b0, 1'b1, -131072};
    tbl[11] = '{1'b1, 32767,  1'b1, 1'b1, -65537};
    tbl[12] = '{1'b0, 0,      1'b0, 1'b1, 131068};
    tbl[13] = '{1'b1, 32767,  1'b1, 1'b1, 131068};
    tbl[14] = '{1'b0, 0,      1'b0, 1'b1, 131068};
    tbl[15] = '{1'b0, 0,      1'b1, 1'b0, 131068};

    arst_n   = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
`ifdef PP_INTERP_BYPASS_EN
    bypass   = 1'b0;
`endif
    model_reset();

    // reset state
    step(1'b0, 1'b1, 55);
    step(1'b0, 1'b0, 0);
    check("reset_valid", int'(act_valid), 0);
    check("reset_data",  act_data,        0);
    step(1'b1, 1'b0, 0);
    check("reset_ready", int'(act_ready), 1);
    check("idle_valid",  int'(act_valid), 0);

    // table vectors
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_ready", i), int'(act_ready), int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_valid", i), int'(act_valid), int'(tbl[i].e_val));
      check($sformatf("tbl%0d_data",  i), act_data,        tbl[i].e_dat);
    end

    // continuous valid_in: 7 samples accepted every other cycle
    accepted = 0;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1000 + 7 * k);
      if (act_ready) k++;
      check("cont_ready", int'(act_ready), (i % 2 == 0) ? 1 : 0);
      check("cont_valid", int'(act_valid), 1);
      check_model("cont");
    end
    accepted = k;
    check("cont_accepted", accepted, 7);
    step(1'b1, 1'b0, 0);
    check_model("cont_tail");

    // reset while y1 pending, with a non-zero delay line
    step(1'b1, 1'b1, 50);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 100);
    check("pre_rst_data", act_data, 100 + 3 * 50);
    step(1'b0, 1'b0, 0);
    check("midrst_valid", int'(act_valid), 0);
    check("midrst_data",  act_data,        0);
    step(1'b1, 1'b1, 100);
    check("postrst_y0", act_data, 100);
    step(1'b1, 1'b0, 0);
    check("postrst_y1", act_data, 400);
    step(1'b1, 1'b0, 0);
    check("postrst_idle", int'(act_valid), 0);

    // valid_in during PH0 is ignored
    step(1'b1, 1'b1, 10);
    check("busy_y0", act_data, 10 + 3 * 100);
    step(1'b1, 1'b1, 77);
    check("busy_ready", int'(act_ready), 0);
    check("busy_y1",    act_data,        40);
    step(1'b1, 1'b0, 0);
    check("busy_gap", int'(act_valid), 0);
    step(1'b1, 1'b1, 77);
    check("late77_y0", act_data, 77 + 3 * 10);
    step(1'b1, 1'b0, 0);
    check("late77_y1", act_data, 4 * 77);
    step(1'b1, 1'b0, 0);
    check("late77_end", int'(act_valid), 0);

`ifdef PP_INTERP_BYPASS_EN
    // combinational pass-through, no clock edge crossed
    bypass   = 1'b1;
    valid_in = 1'b1;
    data_in  = 16'sd5;
    #1;
    check("byp_data",  int'(data_out),  80);
    check("byp_valid", int'(valid_out), 1);
    check("byp_ready", int'(ready_in),  1);
    bypass   = 1'b0;
    valid_in = 1'b0;
`endif

    // randomized traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) < 6),
           int'($urandom_range(0, 65535)) - 32768);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
